traffic_conflict_monitor: RTL

Safety stage directly downstream of the four-way traffic light controller. Registers the controller's four 3-bit light buses and passes them to the lamp drivers. It also checks every cycle for conflicting greens/yellows, illegal encodings and a stalled controller. On a confirmed fault it latches a fault code and overrides all four approaches with flashing red until an operator clear.

---
 rtl/traffic_conflict_monitor_pkg.sv | 26 ++
 rtl/traffic_conflict_monitor_flash_timer.sv | 38 +++
 rtl/traffic_conflict_monitor.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/traffic_conflict_monitor_pkg.sv
// Shared definitions for the traffic conflict monitor: light encodings,
// fault codes and the monitor state enum.
package traffic_conflict_monitor_pkg;

    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] OFF    = 3'b000;

    localparam logic [2:0] FAULT_NONE     = 3'b000;
    localparam logic [2:0] FAULT_CONFLICT = 3'b001;
    localparam logic [2:0] FAULT_INVALID  = 3'b010;
    localparam logic [2:0] FAULT_STUCK    = 3'b011;

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_PASS    = 2'd1,
        ST_FLASH   = 2'd2
    } monitor_state_t;

    // A bus is legal only when exactly one of its three lamps is lit.
    function automatic logic light_valid(input logic [2:0] light);
        return (light == GREEN) || (light == YELLOW) || (light == RED);
    endfunction

endpackage

// File: rtl/traffic_conflict_monitor_flash_timer.sv
// Flash phase generator. The phase output is the value the lamps should show
// after the coming clock edge, so the lamp register in the top level can load
// it directly and each phase lasts exactly FLASH_HALF cycles. A restart means
// the caller is loading the first "on" cycle itself on that edge.
module traffic_conflict_monitor_flash_timer #(
    parameter int FLASH_HALF = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic phase
);

    localparam int CW = $clog2(FLASH_HALF + 1);
    localparam logic [CW-1:0] LAST = CW'(FLASH_HALF - 1);

    logic [CW-1:0] count;
    logic          shown;

    assign phase = (count == LAST) ? ~shown : shown;

    // Count cycles spent in the current phase and toggle after FLASH_HALF of them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            shown <= 1'b1;
        end else if (restart) begin
            count <= '0;
            shown <= 1'b1;
        end else if (count == LAST) begin
            count <= '0;
            shown <= ~shown;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Safety stage behind the four-way light controller. Registers the four light
// buses toward the lamp drivers, watches for conflicts, illegal encodings and
// a stalled controller, and forces flashing red on a latched fault until an
// operator clear is accepted.
module traffic_conflict_monitor
    import traffic_conflict_monitor_pkg::*;
#(
    parameter int STARTUP_CYCLES = 8,
    parameter int FLASH_HALF     = 4,
    parameter int FILTER         = 2,
    parameter int STUCK_LIMIT    = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] north_light,
    input  logic [2:0] west_light,
    input  logic [2:0] south_light,
    input  logic [2:0] east_light,
    input  logic       clr_fault,
    output logic [2:0] north_lamp,
    output logic [2:0] west_lamp,
    output logic [2:0] south_lamp,
    output logic [2:0] east_lamp,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       flash
);

    localparam int SW = $clog2(STARTUP_CYCLES + 1);
    localparam int VW = $clog2(FILTER + 1);
    localparam int KW = $clog2(STUCK_LIMIT + 1);
    localparam logic [SW-1:0] STARTUP_LAST = SW'(STARTUP_CYCLES - 1);
    localparam logic [VW-1:0] FILTER_MAX   = VW'(FILTER);
    localparam logic [KW-1:0] STUCK_MAX    = KW'(STUCK_LIMIT);
    localparam logic [11:0]   ALL_RED      = {RED, RED, RED, RED};
    localparam logic [11:0]   ALL_OFF      = {OFF, OFF, OFF, OFF};

    monitor_state_t state, state_next;
    logic [SW-1:0]  startup_count, startup_next;
    logic [VW-1:0]  viol_count, viol_next;
    logic [KW-1:0]  stuck_count, stuck_next;
    logic [11:0]    lights, prev_lights, lamps, lamps_next;
    logic           fault_next;
    logic [2:0]     code_next;
    logic           restart, phase;
    logic           invalid, conflict;
    logic [2:0]     non_red_count;

    assign lights = {north_light, west_light, south_light, east_light};

    assign invalid = !(light_valid(north_light) && light_valid(west_light) &&
                       light_valid(south_light) && light_valid(east_light));

    assign non_red_count = 3'(north_light != RED) + 3'(west_light != RED) +
                           3'(south_light != RED) + 3'(east_light != RED);
    assign conflict = (non_red_count > 3'd1);

    assign {north_lamp, west_lamp, south_lamp, east_lamp} = lamps;

    traffic_conflict_monitor_flash_timer #(
        .FLASH_HALF(FLASH_HALF)
    ) u_flash_timer (
        .clk    (clk),
        .rst    (rst),
        .restart(restart),
        .phase  (phase)
    );

    // Next state, counter updates and the values the output registers take.
    always_comb begin
        state_next   = state;
        startup_next = '0;
        viol_next    = '0;
        stuck_next   = '0;
        fault_next   = fault;
        code_next    = fault_code;
        lamps_next   = phase ? ALL_RED : ALL_OFF;
        restart      = 1'b0;
        case (state)
            ST_STARTUP: begin
                if (startup_count == STARTUP_LAST) begin
                    state_next = ST_PASS;
                    lamps_next = lights;
                end else begin
                    startup_next = startup_count + 1'b1;
                end
            end
            ST_PASS: begin
                lamps_next = lights;
                if (invalid || conflict) begin
                    viol_next = (viol_count == FILTER_MAX) ? viol_count : viol_count + 1'b1;
                end
                if (lights == prev_lights) begin
                    stuck_next = (stuck_count == STUCK_MAX) ? stuck_count : stuck_count + 1'b1;
                end
                if ((viol_next == FILTER_MAX) || (stuck_next == STUCK_MAX)) begin
                    state_next = ST_FLASH;
                    fault_next = 1'b1;
                    lamps_next = ALL_RED;
                    restart    = 1'b1;
                    if (invalid) begin
                        code_next = FAULT_INVALID;
                    end else if (conflict) begin
                        code_next = FAULT_CONFLICT;
                    end else begin
                        code_next = FAULT_STUCK;
                    end
                end
            end
            ST_FLASH: begin
                if (clr_fault && !invalid && !conflict) begin
                    state_next = ST_STARTUP;
                    fault_next = 1'b0;
                    code_next  = FAULT_NONE;
                    lamps_next = ALL_RED;
                    restart    = 1'b1;
                end
            end
            default: begin
                state_next = ST_STARTUP;
                lamps_next = ALL_RED;
                restart    = 1'b1;
            end
        endcase
    end

    // State, counters and registered outputs; reset forces the safe all-red startup.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_STARTUP;
            startup_count <= '0;
            viol_count    <= '0;
            stuck_count   <= '0;
            prev_lights   <= '0;
            lamps         <= ALL_RED;
            fault         <= 1'b0;
            fault_code    <= FAULT_NONE;
            flash         <= 1'b1;
        end else begin
            state         <= state_next;
            startup_count <= startup_next;
            viol_count    <= viol_next;
            stuck_count   <= stuck_next;
            prev_lights   <= lights;
            lamps         <= lamps_next;
            fault         <= fault_next;
            fault_code    <= code_next;
            flash         <= (state_next != ST_PASS);
        end
    end

endmodule
